axi4lite_indirect_bank: RTL and testbench



---
 rtl/axi4lite_indirect_bank.sv | 233 +++++++++++++++++++++++
 tb/tb_axi4lite_indirect_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_indirect_bank.sv
// axi4lite_indirect_bank
//   A bank of CHANNELS indirect register arrays behind one AXI4-Lite slave.
//   Each channel exposes an INDEX/DATA window onto ENTRIES words of WIDTH bits,
//   plus CTRL (auto-increment, set-only lock) and STATUS (sticky range error).
//   Channel c is at c*0x10: +0x0 INDEX, +0x4 DATA, +0x8 CTRL, +0xC STATUS.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_aw*/o_awready         write address channel
//   i_w*/o_wready           write data channel (32-bit data, 4 byte strobes)
//   o_b*/i_bready           write response channel
//   i_ar*/o_arready         read address channel
//   o_r*/i_rready           read data channel
//   i_write_enable          per-channel hardware gate on DATA writes
//   o_value                 all storage words, channel-major
//   o_locked                per-channel lock state
//
// Optional feature macro: AXI_INDIRECT_BANK_ERROR_EN
//   Defined: unmapped addresses, STATUS writes and out-of-range DATA accesses
//   answer SLVERR. Undefined: those accesses answer OKAY.

module axi4lite_indirect_bank #(
   parameter int unsigned      ADDRESS_WIDTH = 8,
   parameter int unsigned      CHANNELS      = 2,
   parameter int unsigned      ENTRIES       = 8,
   parameter int unsigned      WIDTH         = 8,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
   parameter bit               WRITE_FIRST   = 1'b1
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_awvalid,
   output logic                               o_awready,
   input  logic [ADDRESS_WIDTH-1:0]           i_awaddr,
   input  logic                               i_wvalid,
   output logic                               o_wready,
   input  logic [31:0]                        i_wdata,
   input  logic [3:0]                         i_wstrb,
   output logic                               o_bvalid,
   input  logic                               i_bready,
   output logic [1:0]                         o_bresp,
   input  logic                               i_arvalid,
   output logic                               o_arready,
   input  logic [ADDRESS_WIDTH-1:0]           i_araddr,
   output logic                               o_rvalid,
   input  logic                               i_rready,
   output logic [31:0]                        o_rdata,
   output logic [1:0]                         o_rresp,
   input  logic [CHANNELS-1:0]                i_write_enable,
   output logic [CHANNELS*ENTRIES*WIDTH-1:0]  o_value,
   output logic [CHANNELS-1:0]                o_locked
);

`ifdef AXI_INDIRECT_BANK_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int unsigned IW  = (ENTRIES > 2) ? $clog2(ENTRIES) : 1;
   localparam int unsigned CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {StIdle, StWresp, StRdata} state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_mem [CHANNELS][ENTRIES];
   logic [IW-1:0]       r_index [CHANNELS];
   logic [CHANNELS-1:0] r_auto;
   logic [CHANNELS-1:0] r_lock;
   logic [CHANNELS-1:0] r_rerr;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic                r_rvalid;
   logic [1:0]          r_rresp;
   logic [31:0]         r_rdata;

   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   // Address decode; the channel field is compared at full width so that
   // unmapped channels are caught before the truncated index is used.
   logic [31:0]   w_aw_chan, w_ar_chan;
   logic          w_aw_map, w_ar_map;
   logic [CIW-1:0] w_awch, w_arch;
   logic [1:0]    w_awoff, w_aroff;
   logic [IW-1:0] w_wr_idx, w_rd_idx, w_wr_idx_next, w_rd_idx_next;
   logic          w_wr_inr, w_rd_inr;
   logic [31:0]   w_idx_merged, w_mem_merged;
   logic          w_wr_take, w_rd_take, w_wr_err;
   logic [31:0]   w_rd_data;
   logic          w_rd_err;

   assign w_aw_chan = 32'(i_awaddr >> 4);
   assign w_ar_chan = 32'(i_araddr >> 4);
   assign w_aw_map  = (w_aw_chan < CHANNELS);
   assign w_ar_map  = (w_ar_chan < CHANNELS);
   assign w_awch    = w_aw_chan[CIW-1:0];
   assign w_arch    = w_ar_chan[CIW-1:0];
   assign w_awoff   = i_awaddr[3:2];
   assign w_aroff   = i_araddr[3:2];

   assign w_wr_idx = r_index[w_awch];
   assign w_rd_idx = r_index[w_arch];
   assign w_wr_inr = (32'(w_wr_idx) < ENTRIES);
   assign w_rd_inr = (32'(w_rd_idx) < ENTRIES);
   // Out-of-range indices also wrap to zero.
   assign w_wr_idx_next = (32'(w_wr_idx) >= ENTRIES - 1) ? '0 : w_wr_idx + IW'(1);
   assign w_rd_idx_next = (32'(w_rd_idx) >= ENTRIES - 1) ? '0 : w_rd_idx + IW'(1);

   assign w_idx_merged = f_merge(32'(w_wr_idx), i_wdata, i_wstrb);
   assign w_mem_merged = f_merge(32'(r_mem[w_awch][w_wr_idx]), i_wdata, i_wstrb);

   assign w_wr_take = !i_rst && (r_state == StIdle) && i_awvalid && i_wvalid &&
                      (WRITE_FIRST || !i_arvalid);
   assign w_rd_take = !i_rst && (r_state == StIdle) && i_arvalid && !w_wr_take;

   assign w_wr_err = ERR_EN && (!w_aw_map || (w_awoff == 2'd3) ||
                                ((w_awoff == 2'd1) && !w_wr_inr));

   always_comb begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
      if (!w_ar_map) begin
         w_rd_err = ERR_EN;
      end else begin
         case (w_aroff)
            2'd0: w_rd_data = 32'(w_rd_idx);
            2'd1: begin
               if (w_rd_inr) w_rd_data = 32'(r_mem[w_arch][w_rd_idx]);
               else          w_rd_err  = ERR_EN;
            end
            2'd2: w_rd_data = {30'b0, r_lock[w_arch], r_auto[w_arch]};
            default: w_rd_data = {16'b0, 8'(ENTRIES - 1), 7'b0, r_rerr[w_arch]};
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
         r_rvalid <= 1'b0;
         r_rresp  <= 2'b00;
         r_rdata  <= '0;
         r_auto   <= '0;
         r_lock   <= '0;
         r_rerr   <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            r_index[c] <= '0;
            for (int e = 0; e < ENTRIES; e++) r_mem[c][e] <= INITIAL_VALUE;
         end
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_wr_take) begin
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
                  r_state  <= StWresp;
                  if (w_aw_map) begin
                     case (w_awoff)
                        2'd0: r_index[w_awch] <= w_idx_merged[IW-1:0];
                        2'd1: begin
                           if (w_wr_inr && !r_lock[w_awch] && i_write_enable[w_awch])
                              r_mem[w_awch][w_wr_idx] <= w_mem_merged[WIDTH-1:0];
                           if (!w_wr_inr) r_rerr[w_awch] <= 1'b1;
                           if (r_auto[w_awch]) r_index[w_awch] <= w_wr_idx_next;
                        end
                        2'd2: begin
                           if (i_wstrb[0]) begin
                              r_auto[w_awch] <= i_wdata[0];
                              if (i_wdata[1]) r_lock[w_awch] <= 1'b1;
                              if (i_wdata[2]) r_rerr[w_awch] <= 1'b0;
                           end
                        end
                        default: ;
                     endcase
                  end
               end else if (w_rd_take) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_rd_data;
                  r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
                  r_state  <= StRdata;
                  if (w_ar_map && (w_aroff == 2'd1)) begin
                     if (!w_rd_inr) r_rerr[w_arch] <= 1'b1;
                     if (r_auto[w_arch]) r_index[w_arch] <= w_rd_idx_next;
                  end
               end
            end
            StWresp: begin
               if (i_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= StIdle;
               end
            end
            StRdata: begin
               if (i_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_awready = w_wr_take;
   assign o_wready  = w_wr_take;
   assign o_arready = w_rd_take;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_bresp;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;
   assign o_rresp   = r_rresp;
   assign o_locked  = r_lock;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
         assign o_value[(c*ENTRIES+e)*WIDTH +: WIDTH] = r_mem[c][e];
      end
   end

   logic w_unused;
   assign w_unused = ^{i_awaddr[1:0], i_araddr[1:0], w_aw_chan, w_ar_chan, w_idx_merged,
                       w_mem_merged};

endmodule

// File: tb/tb_axi4lite_indirect_bank.sv
// tb_axi4lite_indirect_bank
//   Directed bench: two instances (ENTRIES=8 and ENTRIES=6) share one stimulus
//   bus. Handshake timing follows the ENTRIES=8 instance; the ENTRIES=6
//   instance covers the out-of-range index behaviour.

module tb_axi4lite_indirect_bank;

`ifdef AXI_INDIRECT_BANK_ERROR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [7:0]  awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [1:0]  we;

   logic        awready8, wready8, bvalid8, arready8, rvalid8;
   logic [1:0]  bresp8, rresp8, locked8;
   logic [31:0] rdata8;
   logic [127:0] value8;

   logic        awready6, wready6, bvalid6, arready6, rvalid6;
   logic [1:0]  bresp6, rresp6, locked6;
   logic [31:0] rdata6;
   logic [95:0] value6;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi4lite_indirect_bank #(
      .ADDRESS_WIDTH(8), .CHANNELS(2), .ENTRIES(8), .WIDTH(8),
      .INITIAL_VALUE(8'h5A), .WRITE_FIRST(1'b1)
   ) u_dut8 (
      .i_clk(clk), .i_rst(rst),
      .i_awvalid(awvalid), .o_awready(awready8), .i_awaddr(awaddr),
      .i_wvalid(wvalid), .o_wready(wready8), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid8), .i_bready(bready), .o_bresp(bresp8),
      .i_arvalid(arvalid), .o_arready(arready8), .i_araddr(araddr),
      .o_rvalid(rvalid8), .i_rready(rready), .o_rdata(rdata8), .o_rresp(rresp8),
      .i_write_enable(we), .o_value(value8), .o_locked(locked8)
   );

   axi4lite_indirect_bank #(
      .ADDRESS_WIDTH(8), .CHANNELS(2), .ENTRIES(6), .WIDTH(8),
      .INITIAL_VALUE(8'h5A), .WRITE_FIRST(1'b1)
   ) u_dut6 (
      .i_clk(clk), .i_rst(rst),
      .i_awvalid(awvalid), .o_awready(awready6), .i_awaddr(awaddr),
      .i_wvalid(wvalid), .o_wready(wready6), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid6), .i_bready(bready), .o_bresp(bresp6),
      .i_arvalid(arvalid), .o_arready(arready6), .i_araddr(araddr),
      .o_rvalid(rvalid6), .i_rready(rready), .o_rdata(rdata6), .o_rresp(rresp6),
      .i_write_enable(we), .o_value(value6), .o_locked(locked6)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      #1;
      n = 0;
      while (!(awready8 && wready8) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("aw_handshake", 128'(n < 20), 128'(1));
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid8 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      resp = bresp8;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d8, output logic [1:0] r8,
                           output logic [31:0] d6, output logic [1:0] r6);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      #1;
      n = 0;
      while (!arready8 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("ar_handshake", 128'(n < 20), 128'(1));
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid8 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      d8 = rdata8; r8 = rresp8; d6 = rdata6; r6 = rresp6;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  br;
      logic [31:0] d8, d6;
      logic [1:0]  r8, r6;

      rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
      rready = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; we = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_bvalid", 128'(bvalid8), 128'(0));
      chk("rst_rvalid", 128'(rvalid8), 128'(0));
      chk("rst_locked", 128'(locked8), 128'(0));
      chk("rst_value8", value8, {16{8'h5A}});
      axi_read(8'h04, d8, r8, d6, r6);
      chk("rd_data_init", 128'(d8), 128'h5A);
      chk("rd_resp_init", 128'(r8), 128'(0));

      // Auto-increment with wrap at ENTRIES-1
      axi_write(8'h08, 32'h1, 4'hF, br);
      axi_write(8'h00, 32'h7, 4'hF, br);
      axi_write(8'h04, 32'h11, 4'hF, br);
      chk("wr_resp_data", 128'(br), 128'(0));
      axi_write(8'h04, 32'h22, 4'hF, br);
      chk("mem0_7", 128'(value8[7*8 +: 8]), 128'h11);
      chk("mem0_0", 128'(value8[0 +: 8]), 128'h22);
      axi_read(8'h00, d8, r8, d6, r6);
      chk("index_after_wrap", 128'(d8), 128'h1);

      // Keep AUTO_INC, clear RANGE_ERR; STATUS carries ENTRIES-1
      axi_write(8'h08, 32'h5, 4'hF, br);
      axi_read(8'h0C, d8, r8, d6, r6);
      chk("status8", 128'(d8), 128'h0700);
      chk("status6_cleared", 128'(d6), 128'h0500);

      // Lock channel 1
      axi_write(8'h18, 32'h2, 4'hF, br);
      chk("lock_resp", 128'(br), 128'(0));
      axi_write(8'h14, 32'hFF, 4'hF, br);
      chk("locked_wr_resp", 128'(br), 128'(0));
      chk("locked_mem1_0", 128'(value8[8*8 +: 8]), 128'h5A);
      chk("locked_vec", 128'(locked8), 128'(2'b10));
      axi_write(8'h18, 32'h0, 4'hF, br);
      chk("lock_sticky", 128'(locked8), 128'(2'b10));
      axi_read(8'h18, d8, r8, d6, r6);
      chk("ctrl1_read", 128'(d8), 128'h2);

      // Hardware write enable and byte strobes
      we = 2'b00;
      axi_write(8'h00, 32'h3, 4'hF, br);
      axi_write(8'h04, 32'h33, 4'hF, br);
      chk("we_off_mem0_3", 128'(value8[3*8 +: 8]), 128'h5A);
      we = 2'b01;
      axi_write(8'h00, 32'h3, 4'hF, br);
      axi_write(8'h04, 32'h33, 4'hF, br);
      chk("we_on_mem0_3", 128'(value8[3*8 +: 8]), 128'h33);
      axi_write(8'h04, 32'hAB, 4'h0, br);
      chk("strb0_mem0_4", 128'(value8[4*8 +: 8]), 128'h5A);
      axi_read(8'h00, d8, r8, d6, r6);
      chk("index_after_strb0", 128'(d8), 128'h5);

      // Out-of-range index on the ENTRIES=6 instance
      axi_write(8'h00, 32'h6, 4'hF, br);
      axi_read(8'h04, d8, r8, d6, r6);
      chk("oor_rresp6", 128'(r6), 128'(ERR));
      chk("oor_rdata6", 128'(d6), 128'(0));
      chk("inr_rdata8", 128'(d8), 128'h5A);
      chk("inr_rresp8", 128'(r8), 128'(0));
      axi_read(8'h0C, d8, r8, d6, r6);
      chk("status6_rerr", 128'(d6), 128'h0501);
      chk("status8_clean", 128'(d8), 128'h0700);
      axi_read(8'h00, d8, r8, d6, r6);
      chk("oor_wrap6", 128'(d6), 128'h0);
      chk("inc8", 128'(d8), 128'h7);

      // Unmapped channel and STATUS write
      axi_read(8'h20, d8, r8, d6, r6);
      chk("unmapped_rresp", 128'(r8), 128'(ERR));
      chk("unmapped_rdata", 128'(d8), 128'(0));
      axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, br);
      chk("status_wr_resp", 128'(br), 128'(ERR));
      axi_read(8'h0C, d8, r8, d6, r6);
      chk("status_wr_ignored", 128'(d8), 128'h0700);

      // Simultaneous write and read: write is served first
      @(negedge clk);
      awaddr = 8'h10; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 8'h10; arvalid = 1'b1;
      #1;
      chk("both_awready", 128'(awready8), 128'(1));
      chk("both_arready_held", 128'(arready8), 128'(0));
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("both_bvalid", 128'(bvalid8), 128'(1));
      chk("wresp_arready", 128'(arready8), 128'(0));
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("idle_arready", 128'(arready8), 128'(1));
      @(posedge clk); #1;
      arvalid = 1'b0;
      chk("rvalid_after", 128'(rvalid8), 128'(1));
      chk("rdata_after_write", 128'(rdata8), 128'h4);

      // Reset while the read response is pending
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_drops_rvalid", 128'(rvalid8), 128'(0));
      chk("rst_value_restore", value8, {16{8'h5A}});
      chk("rst_unlock", 128'(locked8), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      axi_read(8'h08, d8, r8, d6, r6);
      chk("rst_ctrl0", 128'(d8), 128'(0));
      axi_read(8'h10, d8, r8, d6, r6);
      chk("rst_index1", 128'(d8), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
